// File: rtl/conv_filter_stream.sv
// Streamed strided 2-D convolution: loads F*F taps then an N*N map, one MAC per clock, optional zero pad and ReLU.
// Each output appears F*F cycles after the last load word or the previous handshake, and is held until out_ready.
module conv_filter_stream #(
  parameter int input_size  = 7,
  parameter int filter_size = 3,
  parameter int stride      = 2,
  parameter int pad         = 0,
  parameter int data_width  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_data,
  input  logic                  relu_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int N     = input_size;
  localparam int F     = filter_size;
  localparam int FF    = F * F;
  localparam int NN    = N * N;
  localparam int TOTAL = FF + NN;
  localparam int OUT   = (N + 2 * pad - F) / stride + 1;
  localparam int FA    = (FF > 1) ? $clog2(FF) : 1;
  localparam int MA    = (NN > 1) ? $clog2(NN) : 1;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int TW    = $clog2(F + 1);
  localparam int OW    = $clog2(OUT + 1);

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_OUTPUT  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FA-1:0]         tap_q, tap_d;
  logic [TW-1:0]         tr_q, tr_d, tc_q, tc_d;
  logic [OW-1:0]         wr_q, wr_d, wc_q, wc_d;
  logic [data_width-1:0] acc_q, acc_d;
  logic [data_width-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  relu_q, relu_d;

  logic [data_width-1:0] filt_mem [FF];
  logic [data_width-1:0] map_mem  [NN];

  int                    r_pos, c_pos;
  logic                  in_map;
  logic [MA-1:0]         map_idx;
  logic [data_width-1:0] tap_val, prod, sum;

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_OUTPUT);
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = !((state_q == ST_LOAD) && (cnt_q == '0));

  // Storage is not reset; every frame rewrites all of it before use.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      if (cnt_q < CW'(FF))
        filt_mem[FA'(cnt_q)] <= in_data;
      else
        map_mem[MA'(cnt_q - CW'(FF))] <= in_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tap_d      = tap_q;
    tr_d       = tr_q;
    tc_d       = tc_q;
    wr_d       = wr_q;
    wc_d       = wc_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    relu_d     = relu_q;

    // Padded coordinates; taps landing in the border contribute zero.
    r_pos   = int'(wr_q) * stride + int'(tr_q) - pad;
    c_pos   = int'(wc_q) * stride + int'(tc_q) - pad;
    in_map  = (r_pos >= 0) && (r_pos < N) && (c_pos >= 0) && (c_pos < N);
    map_idx = in_map ? MA'(r_pos * N + c_pos) : '0;
    tap_val = in_map ? map_mem[map_idx] : '0;
    prod    = filt_mem[tap_q] * tap_val;
    sum     = acc_q + prod;

    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          if (cnt_q == '0)
            relu_d = relu_en;
          if (cnt_q == CW'(TOTAL - 1)) begin
            cnt_d   = '0;
            state_d = ST_COMPUTE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_COMPUTE: begin
        if (tap_q == FA'(FF - 1)) begin
          tap_d      = '0;
          tr_d       = '0;
          tc_d       = '0;
          acc_d      = '0;
          out_data_d = (relu_q && sum[data_width-1]) ? '0 : sum;
          out_last_d = (wr_q == OW'(OUT - 1)) && (wc_q == OW'(OUT - 1));
          state_d    = ST_OUTPUT;
        end else begin
          tap_d = tap_q + FA'(1);
          acc_d = sum;
          if (tc_q == TW'(F - 1)) begin
            tc_d = '0;
            tr_d = tr_q + TW'(1);
          end else begin
            tc_d = tc_q + TW'(1);
          end
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          out_last_d = 1'b0;
          acc_d      = '0;
          if (out_last_q) begin
            wr_d    = '0;
            wc_d    = '0;
            state_d = ST_LOAD;
          end else begin
            if (wc_q == OW'(OUT - 1)) begin
              wc_d = '0;
              wr_d = wr_q + OW'(1);
            end else begin
              wc_d = wc_q + OW'(1);
            end
            state_d = ST_COMPUTE;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      tap_q      <= '0;
      tr_q       <= '0;
      tc_q       <= '0;
      wr_q       <= '0;
      wc_q       <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      relu_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tap_q      <= tap_d;
      tr_q       <= tr_d;
      tc_q       <= tc_d;
      wr_q       <= wr_d;
      wc_q       <= wc_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      relu_q     <= relu_d;
    end
  end

endmodule
